// File: rtl/secded_pkg.sv
// Shared definitions for the parametrised Hamming SECDED decoder.
//   hw_of(data_w) : number of Hamming check bits, smallest r with 2^r >= data_w + r + 1
//   is_pow2(pos)  : true for check-bit positions (1, 2, 4, ...)
//   data_pos(k)   : code-word position holding data bit k (k-th non-power-of-two position >= 3)
//   err_class_t   : decode classification of one word
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SGL   = 2'd1,
        DBL   = 2'd2
    } err_class_t;

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    function automatic int hw_of(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r;
    endfunction

    function automatic int data_pos(input int k);
        int n;
        int p;
        n = -1;
        p = 2;
        while (n < k) begin
            p++;
            if (!is_pow2(p)) n++;
        end
        return p;
    endfunction

endpackage

// File: rtl/secded_syn.sv
// Combinational syndrome / parity / data-extraction block for one SECDED code word.
//   cw   : code word, bit 0 = overall parity, bits 1..CW-1 = Hamming positions
//   syn  : XOR of the indices of all set bits in positions 1..CW-1
//   par  : XOR of all CW bits (1 = odd number of flips)
//   data : raw data bits gathered from the non-power-of-two positions, ascending
module secded_syn
    import secded_pkg::*;
#(
    parameter int  DATA_W = 64,
    localparam int HW     = hw_of(DATA_W),
    localparam int CW     = DATA_W + HW + 1
) (
    input  logic [CW-1:0]     cw,
    output logic [HW-1:0]     syn,
    output logic              par,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW; i++) begin
            if (cw[i]) syn = syn ^ HW'(i);
        end
    end

    assign par = ^cw;

    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        localparam int P = data_pos(k);
        assign data[k] = cw[P];
    end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready flow control.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_cw carries the code word, corr_en travels with it
//   out_valid/out_ready  : output handshake; out_data, out_sgl, out_dbl, out_pos held while stalled
//   cnt_clr              : clears both error counters (wins over a same-cycle increment)
//   sgl_cnt / dbl_cnt    : saturating counts of accepted results flagged single / double error
// Stage 1 registers syndrome, parity and raw data; stage 2 corrects and classifies.
// Both stages advance together whenever the output slot is free or being drained.
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter int  DATA_W = 64,
    parameter int  CNT_W  = 16,
    localparam int HW     = hw_of(DATA_W),
    localparam int CW     = DATA_W + HW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_cw,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sgl,
    output logic              out_dbl,
    output logic [HW-1:0]     out_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    function automatic err_class_t classify(input logic [HW-1:0] s, input logic p);
        err_class_t c;
        if (!p)                 c = (s == '0) ? CLEAN : DBL;
        else if (int'(s) < CW)  c = SGL;
        else                    c = DBL;  // odd parity but syndrome points past the word
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic              adv;
    logic              out_xfer;
    logic [HW-1:0]     syn_p0;
    logic              par_p0;
    logic [DATA_W-1:0] data_p0;

    logic              vld_p1;
    logic              corr_p1;
    logic              par_p1;
    logic [HW-1:0]     syn_p1;
    logic [DATA_W-1:0] data_p1;
    err_class_t        cls_p1;
    logic [DATA_W-1:0] hit_p1;
    logic [DATA_W-1:0] data_fix_p1;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign out_xfer = out_valid & out_ready;

    // Stage 1: syndrome, overall parity and raw data extraction
    secded_syn #(.DATA_W(DATA_W)) u_syn (
        .cw   (in_cw),
        .syn  (syn_p0),
        .par  (par_p0),
        .data (data_p0)
    );

    always_ff @(posedge clk) begin
        if (rst)      vld_p1 <= 1'b0;
        else if (adv) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            syn_p1  <= syn_p0;
            par_p1  <= par_p0;
            data_p1 <= data_p0;
            corr_p1 <= corr_en;
        end
    end

    // Stage 2: classification and single-bit correction
    assign cls_p1 = classify(syn_p1, par_p1);

    // hit_p1[k] marks the data bit whose position equals the syndrome; syndrome 0 or a
    // check-bit position matches no data bit, so the data passes unchanged.
    for (genvar k = 0; k < DATA_W; k++) begin : g_hit
        localparam int P = data_pos(k);
        assign hit_p1[k] = (syn_p1 == HW'(P));
    end

    assign data_fix_p1 = (corr_p1 && cls_p1 == SGL) ? (data_p1 ^ hit_p1) : data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sgl   <= 1'b0;
            out_dbl   <= 1'b0;
            out_pos   <= '0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= vld_p1;
            out_sgl   <= vld_p1 & (cls_p1 == SGL);
            out_dbl   <= vld_p1 & (cls_p1 == DBL);
            out_pos   <= syn_p1;
            out_data  <= data_fix_p1;
        end
    end

    // Output side: error statistics on accepted results
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (out_xfer) begin
            if (out_sgl) sgl_cnt <= sat_inc(sgl_cnt);
            if (out_dbl) dbl_cnt <= sat_inc(dbl_cnt);
        end
    end

endmodule

// File: tb/tb_secded_dec_pipe.sv
`timescale 1ns/1ps
module tb_secded_dec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // 64-bit decoder, 16-bit counters
    logic        in_valid0 = 1'b0, corr0 = 1'b1, out_ready0 = 1'b1, cnt_clr0 = 1'b0;
    logic        in_ready0, out_valid0, out_sgl0, out_dbl0;
    logic [71:0] in_cw0 = '0;
    logic [63:0] out_data0;
    logic [6:0]  out_pos0;
    logic [15:0] sgl_cnt0, dbl_cnt0;

    // 32-bit decoder, 2-bit counters
    logic        in_valid1 = 1'b0, corr1 = 1'b1, out_ready1 = 1'b1, cnt_clr1 = 1'b0;
    logic        in_ready1, out_valid1, out_sgl1, out_dbl1;
    logic [38:0] in_cw1 = '0;
    logic [31:0] out_data1;
    logic [5:0]  out_pos1;
    logic [1:0]  sgl_cnt1, dbl_cnt1;

    secded_dec_pipe #(.DATA_W(64), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_cw(in_cw0),
        .corr_en(corr0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_sgl(out_sgl0), .out_dbl(out_dbl0), .out_pos(out_pos0), .cnt_clr(cnt_clr0),
        .sgl_cnt(sgl_cnt0), .dbl_cnt(dbl_cnt0));

    secded_dec_pipe #(.DATA_W(32), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_cw(in_cw1),
        .corr_en(corr1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sgl(out_sgl1), .out_dbl(out_dbl1), .out_pos(out_pos1), .cnt_clr(cnt_clr1),
        .sgl_cnt(sgl_cnt1), .dbl_cnt(dbl_cnt1));

    typedef struct {
        logic [63:0] data;
        bit          sgl;
        bit          dbl;
        int          pos;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    int          ms[2], md[2];
    bit          pst[2];
    logic [63:0] pdat[2];
    bit          psgl[2], pdbl[2];
    int          ppos[2];

    int stall_left = 0;
    bit rnd_bp = 1'b0;

    // ---------------- reference model ----------------
    function automatic bit ispow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    function automatic int hw_for(input int dw);
        int r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    // data bits occupy the non-power-of-two positions from 3 upward, in order
    function automatic logic [127:0] enc(input logic [63:0] d, input int dw);
        logic [127:0] c = '0;
        int cw = dw + hw_for(dw) + 1;
        int k = 0;
        for (int p = 3; p < cw; p++) begin
            if (!ispow2(p)) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int p = 1; p < cw; p = p * 2) begin
            bit x = 1'b0;
            for (int j = 1; j < cw; j++) if ((j & p) != 0 && j != p) x ^= c[j];
            c[p] = x;
        end
        c[0] = ^c;
        return c;
    endfunction

    // flip the data bit stored at code position p (no-op for parity/check positions)
    function automatic logic [63:0] flipd(input logic [63:0] d, input int p);
        int np = 0;
        logic [63:0] r = d;
        if (p == 0 || ispow2(p)) return r;
        for (int q = 1; q <= p; q = q * 2) np++;
        r[p - np - 1] = ~r[p - np - 1];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send(input int id, input logic [63:0] d_in, input int fa, input int fb,
                        input int fc, input bit corr);
        int dw, cw, syn, n, waited;
        int fl[3];
        logic [127:0] c;
        logic [63:0]  d, raw;
        exp_t e;
        bit ok;
        dw = (id == 0) ? 64 : 32;
        cw = dw + hw_for(dw) + 1;
        d  = (id == 0) ? d_in : {32'b0, d_in[31:0]};
        c  = enc(d, dw);
        raw = d;
        syn = 0;
        n = 0;
        fl[0] = fa; fl[1] = fb; fl[2] = fc;
        for (int i = 0; i < 3; i++) begin
            if (fl[i] >= 0) begin
                c[fl[i]] = ~c[fl[i]];
                syn ^= fl[i];
                n++;
                raw = flipd(raw, fl[i]);
            end
        end
        e.sgl = 1'b0; e.dbl = 1'b0; e.pos = syn; e.data = raw;
        if (n % 2 == 0)   e.dbl = (syn != 0);
        else if (syn < cw) begin
            e.sgl = 1'b1;
            if (corr) e.data = flipd(raw, syn);
        end else          e.dbl = 1'b1;

        if (id == 0) begin in_cw0 = c[71:0]; corr0 = corr; in_valid0 = 1'b1; end
        else         begin in_cw1 = c[38:0]; corr1 = corr; in_valid1 = 1'b1; end
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            ok = (id == 0) ? in_ready0 : in_ready1;
            if (!ok) begin
                @(posedge clk); #1;
                waited++;
            end
        end
        if (ok) begin
            if (id == 0) q0.push_back(e); else q1.push_back(e);
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL send%0d: in_ready stayed 0 for %0d cycles, required 1", id, waited);
        end
        if (id == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    endtask

    task automatic drain(input int id);
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < 300) begin
            @(negedge clk);
            busy = (id == 0) ? (q0.size() != 0 || out_valid0) : (q1.size() != 0 || out_valid1);
            n++;
        end
        @(posedge clk); #1;
        if (busy) begin
            checks++; errors++;
            $display("FAIL drain%0d: words outstanding after %0d cycles, required 0", id, n);
        end
    endtask

    // out_ready owner for the 64-bit decoder: forced stalls or random backpressure
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            out_ready0 = 1'b0;
            stall_left--;
        end else begin
            out_ready0 = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int id, input bit r, input bit v, input bit rdy, input bit ir,
                       input logic [63:0] dat, input bit s, input bit db, input int pos,
                       input bit clr, input int sc, input int dc);
        int    mx;
        exp_t  e;
        bit    have;
        string t;
        t  = (id == 0) ? "d64" : "d32";
        mx = (id == 0) ? 65535 : 3;
        have = 1'b0;
        chk({t, " sgl_cnt"}, 64'(sc), 64'(ms[id]));
        chk({t, " dbl_cnt"}, 64'(dc), 64'(md[id]));
        if (pst[id]) begin
            chk({t, " hold valid"}, 64'(v), 64'(1));
            chk({t, " hold data"}, dat, pdat[id]);
            chk({t, " hold sgl"}, 64'(s), 64'(psgl[id]));
            chk({t, " hold dbl"}, 64'(db), 64'(pdbl[id]));
            chk({t, " hold pos"}, 64'(pos), 64'(ppos[id]));
        end
        if (v && !rdy) chk({t, " in_ready stalled"}, 64'(ir), 64'(0));
        if (r) begin
            ms[id] = 0;
            md[id] = 0;
            if (id == 0) q0.delete(); else q1.delete();
        end else begin
            if (v && rdy) begin
                if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL %s extra output: got data 0x%0h, expected no word", t, dat);
                end else begin
                    if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
                    have = 1'b1;
                    chk({t, " data"}, dat, e.data);
                    chk({t, " sgl"}, 64'(s), 64'(e.sgl));
                    chk({t, " dbl"}, 64'(db), 64'(e.dbl));
                    chk({t, " pos"}, 64'(pos), 64'(e.pos));
                end
            end
            if (clr) begin
                ms[id] = 0;
                md[id] = 0;
            end else if (have) begin
                if (e.sgl && ms[id] < mx) ms[id]++;
                if (e.dbl && md[id] < mx) md[id]++;
            end
        end
        pst[id]  = !r && v && !rdy;
        pdat[id] = dat;
        psgl[id] = s;
        pdbl[id] = db;
        ppos[id] = pos;
    endtask

    always @(negedge clk)
        mon(0, rst, out_valid0, out_ready0, in_ready0, out_data0, out_sgl0, out_dbl0,
            int'(out_pos0), cnt_clr0, int'(sgl_cnt0), int'(dbl_cnt0));

    always @(negedge clk)
        mon(1, rst, out_valid1, out_ready1, in_ready1, 64'(out_data1), out_sgl1, out_dbl1,
            int'(out_pos1), cnt_clr1, int'(sgl_cnt1), int'(dbl_cnt1));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;

    initial begin
        int n, pa, pb, pc;
        logic [63:0] rd;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst out_valid", 64'(out_valid0), 64'(0));
        chk("rst in_ready", 64'(in_ready0), 64'(1));
        chk("rst out_data", out_data0, 64'(0));
        chk("rst out_pos", 64'(out_pos0), 64'(0));
        chk("rst flags", 64'({out_sgl0, out_dbl0}), 64'(0));
        chk("rst counters", 64'({sgl_cnt0, dbl_cnt0}), 64'(0));

        // clean word and its latency
        send(0, D, -1, -1, -1, 1'b1);
        chk("latency cycle1 out_valid", 64'(out_valid0), 64'(0));
        @(posedge clk); #1;
        chk("latency cycle2 out_valid", 64'(out_valid0), 64'(1));
        drain(0);

        // single error at 37, corrected and raw
        send(0, D, 37, -1, -1, 1'b1);
        drain(0);
        chk("t2 sgl_cnt", 64'(sgl_cnt0), 64'(1));
        send(0, D, 37, -1, -1, 1'b0);
        drain(0);
        chk("t2 raw sgl_cnt", 64'(sgl_cnt0), 64'(2));

        // double error, parity-bit-only error, invalid-position error
        send(0, D, 5, 9, -1, 1'b1);
        drain(0);
        chk("t3 dbl_cnt", 64'(dbl_cnt0), 64'(1));
        send(0, D, 0, -1, -1, 1'b1);
        drain(0);
        chk("t3 bit0 sgl_cnt", 64'(sgl_cnt0), 64'(3));
        send(0, D, 1, 32, 64, 1'b1);
        drain(0);
        chk("t3 invalid pos dbl_cnt", 64'(dbl_cnt0), 64'(2));

        // back-to-back stream with a 3-cycle output stall
        fork
            for (int i = 0; i < 8; i++) send(0, {$urandom, $urandom}, -1, -1, -1, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 stall_left = 3;
            end
        join
        drain(0);

        // random words, 0..3 flipped bits, random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n  = $urandom_range(0, 3);
            pa = $urandom_range(0, 71);
            do pb = $urandom_range(0, 71); while (pb == pa);
            do pc = $urandom_range(0, 71); while (pc == pa || pc == pb);
            rd = {$urandom, $urandom};
            send(0, rd, (n > 0) ? pa : -1, (n > 1) ? pb : -1, (n > 2) ? pc : -1,
                 1'($urandom_range(0, 1)));
        end
        rnd_bp = 1'b0;
        drain(0);

        // 32-bit decoder: position 37 corrected / raw, then counter saturation
        send(1, D, 37, -1, -1, 1'b1);
        send(1, D, 37, -1, -1, 1'b0);
        for (int i = 0; i < 3; i++) send(1, {$urandom, $urandom}, $urandom_range(0, 38), -1, -1, 1'b1);
        drain(1);
        chk("t5 sgl_cnt saturated", 64'(sgl_cnt1), 64'(3));
        send(1, D, 12, -1, -1, 1'b1);
        @(posedge clk); #1;
        chk("t5 clr word at output", 64'(out_valid1), 64'(1));
        cnt_clr1 = 1'b1;
        @(posedge clk); #1;
        cnt_clr1 = 1'b0;
        chk("t5 clr wins over increment", 64'(sgl_cnt1), 64'(0));
        chk("t5 clr word consumed", 64'(out_valid1), 64'(0));
        drain(1);

        // reset with two words in flight
        send(0, D, 37, -1, -1, 1'b1);
        send(0, D, -1, -1, -1, 1'b1);
        chk("t6 pre-reset out_valid", 64'(out_valid0), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6 out_valid", 64'(out_valid0), 64'(0));
        chk("t6 in_ready", 64'(in_ready0), 64'(1));
        chk("t6 sgl_cnt", 64'(sgl_cnt0), 64'(0));
        chk("t6 dbl_cnt", 64'(dbl_cnt0), 64'(0));
        chk("t6 out_data", out_data0, 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6 dropped word", 64'(out_valid0), 64'(0));
        drain(0);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
